// File: rtl/sumador_secuencial_if.sv
// Start/busy/done handshake and operand/result bus of the multi-cycle adder/subtractor.
interface sumador_secuencial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             V;
    logic             Z;

    modport master (
        output start, sub, A, B, C_in,
        input  busy, done, S, C_out, V, Z
    );

    modport slave (
        input  start, sub, A, B, C_in,
        output busy, done, S, C_out, V, Z
    );
endinterface

// File: rtl/sumador_secuencial.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, rippling the carry
// through a register, and publishes S/C_out/V/Z only when the last chunk is done.
module sumador_secuencial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sumador_secuencial_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("sumador_secuencial: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_chunk;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [31:0]      shamt;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new operation may be taken from IDLE or straight out of DONE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

    // The carry into the top bit is recovered from the sum bit, so V needs no extra adder.
    always_comb begin
        shamt      = 32'(cnt) * CHUNK;
        a_chunk    = a_reg[shamt +: CHUNK];
        b_chunk    = b_reg[shamt +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        msb_cin    = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        last_chunk = (cnt == CW'(NCHUNK - 1));
        res_next   = res_reg;
        res_next[shamt +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            bus.S     <= '0;
            bus.C_out <= 1'b0;
            bus.V     <= 1'b0;
            bus.Z     <= 1'b0;
        end else if (accept) begin
            a_reg   <= bus.A;
            b_reg   <= bus.B ^ {WIDTH{bus.sub}};
            carry   <= bus.sub | bus.C_in;
            cnt     <= '0;
            res_reg <= '0;
        end else if (state == RUN) begin
            res_reg <= res_next;
            carry   <= chunk_sum[CHUNK];
            cnt     <= cnt + 1'b1;
            if (last_chunk) begin
                bus.S     <= res_next;
                bus.C_out <= chunk_sum[CHUNK];
                bus.V     <= msb_cin ^ chunk_sum[CHUNK];
                bus.Z     <= (res_next == '0);
            end
        end
    end
endmodule

// File: tb/tb_sumador_secuencial.sv
// Bench for sumador_secuencial: three instances (CHUNK 4, 16, 1) share one stimulus;
// expected results come from a full-width reference model via per-instance queues.
module tb_sumador_secuencial;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         c_in;
    logic [W-1:0] a;
    logic [W-1:0] b;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   run_cnt[3];
    int   last_busy[3];
    int   done_cyc[3];
    exp_t q4[$];
    exp_t qw[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    sumador_secuencial_if #(.WIDTH(W)) bus4 ();
    sumador_secuencial_if #(.WIDTH(W)) busw ();
    sumador_secuencial_if #(.WIDTH(W)) bus1 ();

    assign bus4.start = start; assign bus4.sub = sub; assign bus4.A = a; assign bus4.B = b; assign bus4.C_in = c_in;
    assign busw.start = start; assign busw.sub = sub; assign busw.A = a; assign busw.B = b; assign busw.C_in = c_in;
    assign bus1.start = start; assign bus1.sub = sub; assign bus1.A = a; assign bus1.B = b; assign bus1.C_in = c_in;

    sumador_secuencial #(.WIDTH(W), .CHUNK(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    sumador_secuencial #(.WIDTH(W), .CHUNK(16)) dutw (.clk(clk), .rst(rst), .bus(busw.slave));
    sumador_secuencial #(.WIDTH(W), .CHUNK(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    function automatic logic dut_busy(input int i);
        case (i)
            0:       return bus4.busy;
            1:       return busw.busy;
            default: return bus1.busy;
        endcase
    endfunction

    function automatic logic dut_done(input int i);
        case (i)
            0:       return bus4.done;
            1:       return busw.done;
            default: return bus1.done;
        endcase
    endfunction

    function automatic exp_t dut_out(input int i);
        case (i)
            0:       return {bus4.S, bus4.C_out, bus4.V, bus4.Z};
            1:       return {busw.S, busw.C_out, busw.V, busw.Z};
            default: return {bus1.S, bus1.C_out, bus1.V, bus1.Z};
        endcase
    endfunction

    // Busy cycles per operation and the cycle of each done pulse, per instance.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                run_cnt[i] <= 0;
            end else if (dut_done(i)) begin
                last_busy[i] <= run_cnt[i];
                run_cnt[i]   <= 0;
                done_cyc[i]  <= cyc;
            end else if (dut_busy(i)) begin
                run_cnt[i] <= run_cnt[i] + 1;
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        logic [W-1:0] bo;
        logic [W:0]   full;
        exp_t         e;
        bo   = sv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bo} + (W+1)'(sv ? 1'b1 : cv);
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (av[W-1] == bo[W-1]) && (e.s[W-1] != av[W-1]);
        e.z  = (e.s == '0);
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic cv, input logic sv,
                                  input bit push_all, input bit hold);
        exp_t e;
        a     = av;
        b     = bv;
        c_in  = cv;
        sub   = sv;
        start = 1'b1;
        e     = model(av, bv, cv, sv);
        q4.push_back(e);
        if (push_all) begin
            qw.push_back(e);
            q1.push_back(e);
        end
        tick();
        if (!hold) start = 1'b0;
    endtask

    task automatic check_output(input int i, input int nchunk, input string tag);
        int   n = 0;
        int   qsize;
        exp_t e;
        exp_t got;
        while (dut_done(i) !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check_value({tag, " done"}, W'(dut_done(i)), W'(1));
        if (dut_done(i) === 1'b1) begin
            qsize = (i == 0) ? q4.size() : (i == 1) ? qw.size() : q1.size();
            check_value({tag, " queued"}, W'(qsize > 0), W'(1));
            if (qsize > 0) begin
                case (i)
                    0:       e = q4.pop_front();
                    1:       e = qw.pop_front();
                    default: e = q1.pop_front();
                endcase
                got = dut_out(i);
                check_value({tag, " S"},     got.s,        e.s);
                check_value({tag, " C_out"}, W'(got.c),    W'(e.c));
                check_value({tag, " V"},     W'(got.v),    W'(e.v));
                check_value({tag, " Z"},     W'(got.z),    W'(e.z));
                check_value({tag, " busy"},  W'(last_busy[i]), W'(nchunk));
            end
            tick();
            check_value({tag, " done pulse"}, W'(dut_done(i)), W'(0));
        end
    endtask

    initial begin
        int d1;
        bit seen;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        c_in  = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check_value("reset busy",  W'(bus4.busy), W'(0));
        check_value("reset done",  W'(bus4.done), W'(0));
        check_value("reset S",     bus4.S, W'(0));
        check_value("reset flags", W'({bus4.C_out, bus4.V, bus4.Z}), W'(0));
        rst = 1'b0;
        tick();

        apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 4, "add basic");
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 4, "add wrap");
        apply_stimulus(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output(0, 4, "add cin");
        apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 4, "add ovf");
        apply_stimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output(0, 4, "sub ovf");
        apply_stimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output(0, 4, "sub borrow");
        apply_stimulus(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output(0, 4, "sub zero");

        // A start pulse with new operands while busy must not disturb the running op.
        apply_stimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        sub   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output(0, 4, "start ignored");

        // Start held through done: the next op begins with no idle cycle.
        apply_stimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b1);
        a    = 16'h0001;
        b    = 16'h0001;
        c_in = 1'b0;
        sub  = 1'b0;
        q4.push_back(model(16'h0001, 16'h0001, 1'b0, 1'b0));
        check_output(0, 4, "b2b first");
        d1    = done_cyc[0];
        start = 1'b0;
        check_output(0, 4, "b2b second");
        check_value("b2b spacing", W'(done_cyc[0] - d1), W'(5));

        // Reset in the second RUN cycle aborts immediately.
        apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check_value("abort busy",  W'(bus4.busy), W'(0));
        check_value("abort done",  W'(bus4.done), W'(0));
        check_value("abort S",     bus4.S, W'(0));
        check_value("abort flags", W'({bus4.C_out, bus4.V, bus4.Z}), W'(0));
        tick();
        rst = 1'b0;
        void'(q4.pop_back());
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus4.done) seen = 1'b1;
        end
        check_value("abort no done", W'(seen), W'(0));

        apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output(1, 1,  "chunk16");
        check_output(0, 4,  "rerun");
        check_output(2, 16, "chunk1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
